// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared encodings and helpers for the data memory responder
package data_mem_responder_pkg;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic mask_is_valid(input logic [3:0] mask);
    return (mask == MASK_BYTE) || (mask == MASK_HALF) || (mask == MASK_WORD);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] lo);
    return ((mask == MASK_HALF) && lo[0]) || ((mask == MASK_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/byte_enable_ram.sv
// rtl/byte_enable_ram.sv - single-port word RAM with byte write enables
// Asynchronous read, synchronous write; drop-in point for a vendor macro.
module byte_enable_ram #(
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input  logic                               clk_i,
  input  logic [3:0]                         we_i,
  input  logic [$clog2(MEM_DEPTH_WORDS)-1:0] addr_i,
  input  logic [31:0]                        wdata_i,
  output logic [31:0]                        rdata_o
);

  logic [31:0] mem_q [MEM_DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-port responder: wait-state FSM, fault checks, lane alignment
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          MEM_DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          WAIT_CYCLES     = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDR,
  input  logic [31:0] WR_DATA,
  input  logic        WR_REQ,
  input  logic [3:0]  WR_MASK,
  input  logic        RD_REQ,
  output logic [31:0] RD_DATA,
  output logic        READY,
  output logic        ERROR,
  output logic        BUSY
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  mask_q;
  logic        wr_q, fault_q;

  logic        accept, in_range, fault_in;
  logic        idle, enter_resp;
  logic [31:0] cur_addr, cur_data, lane_data, ram_rdata;
  logic [3:0]  cur_mask, byte_en, ram_we;
  logic        cur_wr, cur_fault;
  logic [AW-1:0] ram_addr;

  assign idle   = (state_q == IDLE);
  assign accept = idle && (RD_REQ || WR_REQ);

  assign in_range = (ADDR >= BASE_ADDR) && (((ADDR - BASE_ADDR) >> (AW + 2)) == 32'd0);
  assign fault_in = (RD_REQ && WR_REQ) || !in_range
                 || is_misaligned(WR_MASK, ADDR[1:0])
                 || (WR_REQ && !mask_is_valid(WR_MASK));

  // With zero wait states the write commits on the acceptance edge, so the
  // live inputs stand in for the not-yet-latched copies while in IDLE.
  assign cur_addr  = idle ? ADDR     : addr_q;
  assign cur_data  = idle ? WR_DATA  : wdata_q;
  assign cur_mask  = idle ? WR_MASK  : mask_q;
  assign cur_wr    = idle ? WR_REQ   : wr_q;
  assign cur_fault = idle ? fault_in : fault_q;

  assign ram_addr   = AW'((cur_addr - BASE_ADDR) >> 2);
  assign byte_en    = cur_mask << cur_addr[1:0];
  assign lane_data  = cur_data << {cur_addr[1:0], 3'b000};
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign ram_we     = (enter_resp && cur_wr && !cur_fault && !RESET) ? byte_en : 4'b0000;

  byte_enable_ram #(
    .MEM_DEPTH_WORDS(MEM_DEPTH_WORDS)
  ) u_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (lane_data),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (RD_REQ || WR_REQ) begin
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
      wr_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= ADDR;
        wdata_q <= WR_DATA;
        mask_q  <= WR_MASK;
        wr_q    <= WR_REQ;
        fault_q <= fault_in;
      end
    end
  end

  assign READY   = (state_q == RESP);
  assign ERROR   = READY && fault_q;
  assign BUSY    = !idle;
  assign RD_DATA = (READY && !wr_q && !fault_q) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [3:0]  wmask;
  logic [2:0]  wr_req, rd_req, ready, error, busy;
  logic [31:0] rd_data [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Unit 0: WAIT_CYCLES=0, unit 1: WAIT_CYCLES=1, unit 2: WAIT_CYCLES=7
  data_mem_responder #(.MEM_DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (
    .CLK(clk), .RESET(rst), .ADDR(addr), .WR_DATA(wdata), .WR_REQ(wr_req[0]), .WR_MASK(wmask),
    .RD_REQ(rd_req[0]), .RD_DATA(rd_data[0]), .READY(ready[0]), .ERROR(error[0]), .BUSY(busy[0]));
  data_mem_responder #(.MEM_DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_w1 (
    .CLK(clk), .RESET(rst), .ADDR(addr), .WR_DATA(wdata), .WR_REQ(wr_req[1]), .WR_MASK(wmask),
    .RD_REQ(rd_req[1]), .RD_DATA(rd_data[1]), .READY(ready[1]), .ERROR(error[1]), .BUSY(busy[1]));
  data_mem_responder #(.MEM_DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(7)) u_w7 (
    .CLK(clk), .RESET(rst), .ADDR(addr), .WR_DATA(wdata), .WR_REQ(wr_req[2]), .WR_MASK(wmask),
    .RD_REQ(rd_req[2]), .RD_DATA(rd_data[2]), .READY(ready[2]), .ERROR(error[2]), .BUSY(busy[2]));

  task automatic access(input int u, input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m,
                        output int lat, output logic err, output logic [31:0] data);
    @(negedge clk);
    addr = a; wdata = d; wmask = m; wr_req[u] = wr; rd_req[u] = rd;
    @(posedge clk);
    lat = -1; err = 1'b0; data = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ready[u]) begin
        lat = i; err = error[u]; data = rd_data[u];
        break;
      end
    end
    wr_req[u] = 1'b0; rd_req[u] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = 32'd0; wdata = 32'd0; wmask = 4'd0; wr_req = 3'd0; rd_req = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", ready); end
    checks++; if (error !== 3'b000) begin errors++; $display("FAIL reset_error got %b exp 000", error); end
    checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b exp 000", busy); end
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (rd_data[u] !== 32'd0) begin errors++; $display("FAIL reset_rd_data[%0d] got %h exp 0", u, rd_data[u]); end
    end
  endtask

  task automatic test_word_store_load();
    int lat; logic err; logic [31:0] data;
    access(1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, lat, err, data);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_lat got %0d exp 2", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL word_store_err got %b exp 0", err); end
    access(1, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF, lat, err, data);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_lat got %0d exp 2", lat); end
    checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_data got %h exp deadbeef", data); end
  endtask

  task automatic test_lanes();
    int lat; logic err; logic [31:0] data;
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lat, err, data);
    access(1, 1'b1, 1'b0, 32'h23, 32'hAB, 4'b0001, lat, err, data);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL byte_store_err got %b exp 0", err); end
    access(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, lat, err, data);
    checks++; if (data !== 32'hAB000000) begin errors++; $display("FAIL byte_lane got %h exp ab000000", data); end
    access(1, 1'b1, 1'b0, 32'h22, 32'h1234, 4'b0011, lat, err, data);
    access(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, lat, err, data);
    checks++; if (data !== 32'h12340000) begin errors++; $display("FAIL half_lane got %h exp 12340000", data); end
    access(1, 1'b1, 1'b0, 32'hFFC, 32'h5A5A0FF0, 4'hF, lat, err, data);
    access(1, 1'b0, 1'b1, 32'hFFC, 32'h0, 4'hF, lat, err, data);
    checks++; if (err !== 1'b0 || data !== 32'h5A5A0FF0) begin
      errors++; $display("FAIL top_word got err=%b data=%h exp err=0 data=5a5a0ff0", err, data); end
  endtask

  task automatic test_faults();
    int lat; logic err; logic [31:0] data;
    access(1, 1'b1, 1'b0, 32'h21, 32'h5678, 4'b0011, lat, err, data);
    checks++; if (lat !== 2 || err !== 1'b1) begin
      errors++; $display("FAIL misaligned_half got lat=%0d err=%b exp lat=2 err=1", lat, err); end
    access(1, 1'b1, 1'b0, 32'h20, 32'hFFFFFFFF, 4'b0101, lat, err, data);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_mask_err got %b exp 1", err); end
    access(1, 1'b0, 1'b1, 32'h1000, 32'h0, 4'hF, lat, err, data);
    checks++; if (err !== 1'b1 || data !== 32'd0) begin
      errors++; $display("FAIL out_of_range got err=%b data=%h exp err=1 data=0", err, data); end
    access(1, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, lat, err, data);
    checks++; if (err !== 1'b1 || data !== 32'd0) begin
      errors++; $display("FAIL rd_wr_both got err=%b data=%h exp err=1 data=0", err, data); end
    access(1, 1'b0, 1'b1, 32'h20, 32'h0, 4'hF, lat, err, data);
    checks++; if (err !== 1'b0 || data !== 32'h12340000) begin
      errors++; $display("FAIL fault_no_write got err=%b data=%h exp err=0 data=12340000", err, data); end
  endtask

  task automatic test_wait_sweep();
    int lat; int busy_bad; logic err; logic [31:0] data;
    access(0, 1'b1, 1'b0, 32'h40, 32'h01020304, 4'hF, lat, err, data);
    checks++; if (lat !== 1) begin errors++; $display("FAIL w0_lat got %0d exp 1", lat); end
    @(negedge clk);
    addr = 32'h40; wdata = 32'hCAFEF00D; wmask = 4'hF; wr_req[2] = 1'b1;
    @(posedge clk);
    lat = -1; err = 1'b1; busy_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!busy[2]) busy_bad++;
      if (ready[2]) begin lat = i; err = error[2]; break; end
      addr = $urandom; wdata = $urandom; wmask = 4'($urandom_range(0, 15));
      wr_req[2] = 1'($urandom_range(0, 1)); rd_req[2] = 1'($urandom_range(0, 1));
    end
    wr_req[2] = 1'b0; rd_req[2] = 1'b0;
    checks++; if (lat !== 8) begin errors++; $display("FAIL w7_lat got %0d exp 8", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL w7_err got %b exp 0", err); end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL w7_busy_low_cycles got %0d exp 0", busy_bad); end
    @(negedge clk);
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL w7_busy_after got %b exp 0", busy[2]); end
    access(2, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, lat, err, data);
    checks++; if (lat !== 8 || data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL w7_load got lat=%0d data=%h exp lat=8 data=cafef00d", lat, data); end
    access(0, 1'b0, 1'b1, 32'h40, 32'h0, 4'hF, lat, err, data);
    checks++; if (lat !== 1 || data !== 32'h01020304) begin
      errors++; $display("FAIL w0_load got lat=%0d data=%h exp lat=1 data=01020304", lat, data); end
  endtask

  task automatic test_reset_mid_access();
    int lat; int seen_ready; logic err; logic [31:0] data;
    access(2, 1'b1, 1'b0, 32'h30, 32'h11111111, 4'hF, lat, err, data);
    @(negedge clk);
    addr = 32'h30; wdata = 32'h22222222; wmask = 4'hF; wr_req[2] = 1'b1;
    @(posedge clk);
    seen_ready = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready[2]) seen_ready++;
    end
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy[2]); end
    rst = 1'b1; wr_req[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    if (ready[2]) seen_ready++;
    checks++; if (seen_ready !== 0) begin errors++; $display("FAIL abort_ready got %0d exp 0", seen_ready); end
    checks++; if (busy[2] !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy[2]); end
    access(2, 1'b0, 1'b1, 32'h30, 32'h0, 4'hF, lat, err, data);
    checks++; if (lat !== 8 || err !== 1'b0 || data !== 32'h11111111) begin
      errors++; $display("FAIL abort_no_write got lat=%0d err=%b data=%h exp lat=8 err=0 data=11111111", lat, err, data); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] rdy_seq;
    logic [31:0] data;
    @(negedge clk);
    addr = 32'h50; wdata = 32'h0BADF00D; wmask = 4'hF; wr_req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy_seq[0] = ready[0];
    wr_req[0] = 1'b0; rd_req[0] = 1'b1;
    @(negedge clk);
    rdy_seq[1] = ready[0];
    @(negedge clk);
    rdy_seq[2] = ready[0];
    data = rd_data[0];
    @(negedge clk);
    rdy_seq[3] = ready[0];
    rd_req[0] = 1'b0;
    checks++; if (rdy_seq !== 4'b1010 && rdy_seq !== 4'b0101) begin
      errors++; $display("FAIL b2b_ready_pattern got %b exp 0101 (lsb first cycle)", rdy_seq); end
    checks++; if (rdy_seq[2:0] !== 3'b101) begin
      errors++; $display("FAIL b2b_ready_first3 got %b exp 101", rdy_seq[2:0]); end
    checks++; if (data !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_load got %h exp 0badf00d", data); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_lanes();
    test_faults();
    test_wait_sweep();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data port. It consumes the write request, size-coded write mask and load requests that the core's decode stage produces.
- Backed by a word-organised internal RAM with a configurable number of wait states.
- Performs byte-lane alignment of writes, detects misaligned and out-of-range accesses, and returns a one-cycle READY/ERROR completion.
- Sits between the core's load/store path and the system bus as the default on-chip data memory.

Parameters:
- MEM_DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two, minimum 4.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to MEM_DEPTH_WORDS*4.
- WAIT_CYCLES, 1, extra cycles between acceptance and completion; range 0..15.

Ports:
- CLK  in  1  sole clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDR  in  32  byte address of the access.
- WR_DATA  in  32  store data, LSB-aligned (byte in [7:0], halfword in [15:0]).
- WR_REQ  in  1  store request.
- WR_MASK  in  4  size-coded, LSB-aligned mask: 0001 byte, 0011 half, 1111 word.
- RD_REQ  in  1  load request.
- RD_DATA  out  32  full aligned word at ADDR[31:2]; valid only while READY=1 for a read.
- READY  out  1  one-cycle completion pulse.
- ERROR  out  1  qualifies READY; the access faulted and had no side effect.
- BUSY  out  1  high from acceptance until completion.

Behaviour:
- Reset: one RESET cycle sets state=IDLE; READY, ERROR and BUSY are 0; RD_DATA is 0; the wait counter is 0. RAM contents are not cleared.
- RESET asserted in any state aborts the access. The write is not committed and no READY is produced.
- State machine:
  - IDLE: if RD_REQ|WR_REQ, latch ADDR, WR_DATA, WR_MASK and the request kind, and set BUSY=1.
    - WAIT_CYCLES=0: go to RESP.
    - Otherwise: load counter=WAIT_CYCLES-1 and go to WAIT.
  - WAIT: decrement the counter; go to RESP when it is 0.
  - RESP: READY=1 for exactly this cycle, BUSY=0 next cycle; go to IDLE.
- Latency: READY rises WAIT_CYCLES+1 cycles after the acceptance edge. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Requests are sampled only in IDLE. Inputs during WAIT/RESP are ignored. The requester holds its request until READY and drops it the cycle after.
- Fault checks use the latched values; evaluate them at acceptance and register the result. A fault gives ERROR=1 with READY, no RAM write, and RD_DATA=0. Fault conditions:
  - RD_REQ and WR_REQ both high.
  - ADDR outside [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH_WORDS - 1].
  - Misaligned access: half with ADDR[0]=1, or word with ADDR[1:0]!=0.
  - A store with WR_MASK not in {0001, 0011, 1111}.
- Store lane alignment:
  - Effective byte enables = WR_MASK << ADDR[1:0].
  - Lane data = WR_DATA << (8*ADDR[1:0]).
  - Only the enabled bytes are written.
  - The write commits on the RESP cycle edge (the same edge that raises READY).
- Load: RD_DATA is the RAM word read combinationally or registered; it must be stable while READY=1. Sign/zero extension and byte selection are done by the core, not here.
- Word index = (ADDR - BASE_ADDR)[log2(MEM_DEPTH_WORDS)+1:2]; no wrap-around, because out-of-range addresses fault.
- A store followed by a load to the same word returns the new data.

Decomposition:
- Shared globals header gets:
  - localparams for the mask encodings (MASK_BYTE=4'b0001, MASK_HALF=4'b0011, MASK_WORD=4'b1111);
  - state encodings IDLE/WAIT/RESP (2 bits).
- One sub-module, byte_enable_ram: MEM_DEPTH_WORDS x 32 RAM with 4-bit byte write-enable, a single port and synchronous write, so it can be swapped for a vendor macro.
- The FSM, fault check and lane shifting stay in data_mem_responder.

Test Plan:
- Word store then load, WAIT_CYCLES=1: WR_REQ, ADDR=0x10, WR_DATA=0xDEADBEEF, mask 1111 -> READY (ERROR=0) 2 cycles after acceptance. Then RD_REQ at 0x10 -> RD_DATA=0xDEADBEEF with READY.
- Byte/half lanes: word 0x20 preset to 0x00000000.
  - Byte store 0xAB at 0x23 -> word reads 0xAB000000.
  - Half store 0x1234 at 0x22 -> word reads 0x12340000.
- Faults:
  - Half store at 0x21 -> READY+ERROR, word 0x20 unchanged.
  - Load at BASE_ADDR + 4*MEM_DEPTH_WORDS -> READY+ERROR, RD_DATA=0.
  - RD_REQ and WR_REQ both high -> READY+ERROR, no write.
- WAIT_CYCLES sweep 0 and 7 -> READY exactly 1 and 8 cycles after acceptance. Inputs toggled during WAIT are ignored; BUSY is high across the access.
- Reset mid-access: store to 0x30 accepted, RESET pulsed in WAIT -> no READY, BUSY=0, word 0x30 retains its old value. A new request next cycle completes normally.
- Back-to-back, WAIT_CYCLES=0: requests held continuously -> READY every 2nd cycle; store then load of the same word returns the stored value.
